// File: rtl/sort4_sequencer_if.sv
// Stream bundle for sort4_sequencer: one input stream (values into the
// frame buffer) and one output stream (sorted values out of it).
//
// Handshake: a beat transfers on a rising clk edge where valid and ready
// are both high. The producer drives valid and data; the consumer drives
// ready. In this block both ready (in_ready) and valid (out_valid) decode
// only from state, so neither depends on the other side's signal in the
// same cycle. While valid is high and ready is low, the data holds.
interface sort4_sequencer_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;

    // Environment side: feeds the input stream and consumes the output stream.
    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  out_data,
        output out_ready
    );

    // Sorter side.
    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        output out_data,
        input  out_ready
    );
endinterface

// File: rtl/sort4_sequencer.sv
// Frame sorter: collects DEPTH 4-bit values, bubble-sorts them in place
// with one shared comparator (one compare per clock, early exit on a
// pass with no swaps), then streams them out smallest first.

// Unsigned 4-bit magnitude comparator shared by all compare steps.
module sort4_comparator (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic       larger_o,
    output logic       equal_o,
    output logic       less_o
);
    assign larger_o = (a_i > b_i);
    assign equal_o  = (a_i == b_i);
    assign less_o   = (a_i < b_i);
endmodule

module sort4_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sort4_sequencer_if.slave     bus,
    output logic                 busy,
    output logic [5:0]           swap_cnt,
    output logic [1:0]           dbg_state_o
);
    // LOAD is encoded as 0 so the reset state reads back as zero on dbg_state_o.
    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SORT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [2:0] LAST_IDX = 3'(DEPTH - 1);
    localparam logic [2:0] LAST_CMP = 3'(DEPTH - 2);
    localparam logic [2:0] LAST_PASS = 3'(DEPTH - 2);

    state_t     state_q, state_d;
    logic [2:0] wr_idx_q, wr_idx_d;
    logic [2:0] rd_idx_q, rd_idx_d;
    logic [2:0] cmp_idx_q, cmp_idx_d;
    logic [2:0] pass_q, pass_d;
    logic       pass_swapped_q, pass_swapped_d;
    logic [5:0] swap_cnt_q, swap_cnt_d;

    // Storage is sized for the largest legal frame; only the first DEPTH
    // entries are ever written after reset.
    logic [3:0] mem_q [8];

    logic       do_write;
    logic       do_swap;
    logic [2:0] cmp_nxt;
    logic [3:0] cmp_a;
    logic [3:0] cmp_b;
    logic       cmp_larger;
    logic       cmp_equal;
    logic       cmp_less;

    assign cmp_nxt = cmp_idx_q + 3'd1;
    assign cmp_a   = mem_q[cmp_idx_q];
    assign cmp_b   = mem_q[cmp_nxt];

    sort4_comparator u_cmp (
        .a_i      (cmp_a),
        .b_i      (cmp_b),
        .larger_o (cmp_larger),
        .equal_o  (cmp_equal),
        .less_o   (cmp_less)
    );

    // Handshake flags and status decode straight from the state register.
    assign bus.in_ready  = (state_q == ST_LOAD);
    assign bus.out_valid = (state_q == ST_DRAIN);
    assign bus.out_data  = (state_q == ST_DRAIN) ? mem_q[rd_idx_q] : 4'd0;
    assign busy          = (state_q == ST_SORT);
    assign swap_cnt      = swap_cnt_q;
    assign dbg_state_o   = state_q;

    // Next-state and index/counter updates for all three phases.
    always_comb begin
        state_d        = state_q;
        wr_idx_d       = wr_idx_q;
        rd_idx_d       = rd_idx_q;
        cmp_idx_d      = cmp_idx_q;
        pass_d         = pass_q;
        pass_swapped_d = pass_swapped_q;
        swap_cnt_d     = swap_cnt_q;
        do_write       = 1'b0;
        do_swap        = 1'b0;

        unique case (state_q)
            ST_LOAD: begin
                if (bus.in_valid) begin
                    do_write = 1'b1;
                    wr_idx_d = wr_idx_q + 3'd1;
                    // The count describes the frame being loaded, so it
                    // restarts on that frame's first beat, not earlier.
                    if (wr_idx_q == 3'd0) begin
                        swap_cnt_d = 6'd0;
                    end
                    if (wr_idx_q == LAST_IDX) begin
                        state_d        = ST_SORT;
                        wr_idx_d       = 3'd0;
                        cmp_idx_d      = 3'd0;
                        pass_d         = 3'd0;
                        pass_swapped_d = 1'b0;
                    end
                end
            end

            ST_SORT: begin
                // Only strictly-greater pairs swap, which keeps equal values in order.
                if (cmp_larger) begin
                    do_swap        = 1'b1;
                    pass_swapped_d = 1'b1;
                    if (swap_cnt_q != 6'd63) begin
                        swap_cnt_d = swap_cnt_q + 6'd1;
                    end
                end
                if (cmp_idx_q != LAST_CMP) begin
                    cmp_idx_d = cmp_nxt;
                end else if ((!pass_swapped_q && (cmp_equal || cmp_less)) ||
                             (pass_q == LAST_PASS)) begin
                    state_d = ST_DRAIN;
                end else begin
                    pass_d         = pass_q + 3'd1;
                    cmp_idx_d      = 3'd0;
                    pass_swapped_d = 1'b0;
                end
            end

            ST_DRAIN: begin
                if (bus.out_ready) begin
                    if (rd_idx_q == LAST_IDX) begin
                        state_d  = ST_LOAD;
                        rd_idx_d = 3'd0;
                    end else begin
                        rd_idx_d = rd_idx_q + 3'd1;
                    end
                end
            end

            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // State, index and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_LOAD;
            wr_idx_q       <= 3'd0;
            rd_idx_q       <= 3'd0;
            cmp_idx_q      <= 3'd0;
            pass_q         <= 3'd0;
            pass_swapped_q <= 1'b0;
            swap_cnt_q     <= 6'd0;
        end else begin
            state_q        <= state_d;
            wr_idx_q       <= wr_idx_d;
            rd_idx_q       <= rd_idx_d;
            cmp_idx_q      <= cmp_idx_d;
            pass_q         <= pass_d;
            pass_swapped_q <= pass_swapped_d;
            swap_cnt_q     <= swap_cnt_d;
        end
    end

    // Frame buffer: written by accepted input beats, rearranged by swaps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                mem_q[i] <= 4'd0;
            end
        end else if (do_write) begin
            mem_q[wr_idx_q] <= bus.in_data;
        end else if (do_swap) begin
            mem_q[cmp_idx_q] <= cmp_b;
            mem_q[cmp_nxt]   <= cmp_a;
        end
    end
endmodule

// File: tb/tb_sort4_sequencer.sv
// Bench for sort4_sequencer (DEPTH=4): directed frames plus random frames,
// checked against a reference that derives sorted order, swap count and
// pass count directly from the frame contents.
module tb_sort4_sequencer;
  localparam int DEPTH = 4;
  typedef logic [3:0] frame_t [DEPTH];

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       busy;
  logic [5:0] swap_cnt;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  sort4_sequencer_if bus();

  sort4_sequencer #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .busy        (busy),
    .swap_cnt    (swap_cnt),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int         n_checks = 0;
  int         n_fail = 0;
  logic [3:0] exp_q[$];
  int         exp_swaps;
  int         exp_passes;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: ascending order by counting sort; bubble-sort swaps equal the
  // number of strict inversions; each pass moves every element left by at
  // most one, so passes = (largest left-displacement) + 1 confirming pass,
  // capped at DEPTH-1.
  function automatic void predict(input frame_t v);
    int max_left;
    int left;
    exp_swaps = 0;
    max_left = 0;
    for (int i = 0; i < DEPTH; i++) begin
      left = 0;
      for (int j = 0; j < i; j++) begin
        if (v[j] > v[i]) left++;
      end
      exp_swaps += left;
      if (left > max_left) max_left = left;
    end
    exp_passes = (max_left + 1 < DEPTH - 1) ? max_left + 1 : DEPTH - 1;
    for (int val = 0; val < 16; val++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (int'(v[i]) == val) exp_q.push_back(v[i]);
      end
    end
  endfunction

  // ---------------- driver tasks ----------------
  // gap_mode: 0 = back-to-back, 1 = idle every other cycle, 2 = random idles.
  // Returns at the negedge inside the first SORT cycle.
  task automatic load_frame(input frame_t v, input int gap_mode, input bit noise);
    int  i;
    bit  toggle;
    bit  idle;
    i = 0;
    toggle = 1'b0;
    predict(v);
    while (i < DEPTH) begin
      @(negedge clk);
      check_val("in_ready_load", bus.in_ready, 1);
      idle = (gap_mode == 1 && toggle) || (gap_mode == 2 && $urandom_range(0, 1) == 1);
      if (idle) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 4'($urandom_range(0, 15));
      end else begin
        bus.in_valid = 1'b1;
        bus.in_data  = v[i];
        i++;
      end
      toggle = !toggle;
    end
    @(negedge clk);
    bus.in_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    bus.in_data  = 4'($urandom_range(0, 15));
  endtask

  task automatic sort_phase();
    int n;
    n = 0;
    while (busy === 1'b1 && n < 64) begin
      n++;
      @(negedge clk);
    end
    check_val("busy_cycles", n, exp_passes * (DEPTH - 1));
    check_val("swap_cnt", swap_cnt, exp_swaps);
    check_val("out_valid_rise", bus.out_valid, 1);
  endtask

  // ready_mode: 0 = always ready, 1 = toggle starting low, 2 = random.
  task automatic drain_phase(input int ready_mode);
    int         got;
    int         cyc;
    bit         stalled;
    bit         r;
    logic [3:0] held;
    got = 0;
    cyc = 0;
    stalled = 1'b0;
    held = 4'd0;
    bus.in_valid = 1'b0;
    while (got < DEPTH && cyc < 200) begin
      check_val("in_ready_drain", bus.in_ready, 0);
      check_val("out_valid_drain", bus.out_valid, 1);
      check_val("swap_cnt_hold", swap_cnt, exp_swaps);
      if (stalled) check_val("out_hold", bus.out_data, held);
      case (ready_mode)
        0:       r = 1'b1;
        1:       r = (cyc % 2) == 1;
        default: r = 1'($urandom_range(0, 1));
      endcase
      bus.out_ready = r;
      if (r) begin
        check_val("out_data", bus.out_data, exp_q.pop_front());
        got++;
        stalled = 1'b0;
      end else begin
        held = bus.out_data;
        stalled = 1'b1;
      end
      cyc++;
      @(negedge clk);
    end
    check_val("drain_beats", got, DEPTH);
    if (ready_mode == 0) check_val("drain_cycles", cyc, DEPTH);
    check_val("in_ready_return", bus.in_ready, 1);
    check_val("out_valid_drop", bus.out_valid, 0);
    bus.out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic run_frame(input frame_t v, input int gap_mode, input int ready_mode, input bit noise);
    load_frame(v, gap_mode, noise);
    sort_phase();
    drain_phase(ready_mode);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    frame_t f;
    bus.in_valid  = 1'b0;
    bus.in_data   = 4'd0;
    bus.out_ready = 1'b0;

    @(negedge clk);
    check_val("rst_in_ready", bus.in_ready, 1);
    check_val("rst_out_valid", bus.out_valid, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_swap_cnt", swap_cnt, 0);
    check_val("rst_out_data", bus.out_data, 0);
    check_val("rst_state", dbg_state, 0);
    rst_n = 1'b1;

    // Reverse order: 3 passes, 6 swaps.
    f = '{4'd12, 4'd9, 4'd3, 4'd1};
    run_frame(f, 0, 0, 1'b0);

    // Already sorted with duplicates: single pass, no swaps.
    f = '{4'd1, 4'd1, 4'd9, 4'd9};
    run_frame(f, 0, 0, 1'b0);

    // Back-pressure on every other cycle.
    f = '{4'd9, 4'd3, 4'd9, 4'd1};
    run_frame(f, 0, 1, 1'b0);

    // Input gaps every other cycle.
    f = '{4'd5, 4'd0, 4'd15, 4'd7};
    run_frame(f, 1, 0, 1'b0);

    // Reset on the 4th SORT cycle, then a fresh all-equal frame.
    f = '{4'd12, 4'd9, 4'd3, 4'd1};
    load_frame(f, 0, 1'b0);
    repeat (3) @(negedge clk);
    check_val("swap_cnt_pre_reset", swap_cnt, 3);
    rst_n = 1'b0;
    #1;
    check_val("midrst_in_ready", bus.in_ready, 1);
    check_val("midrst_out_valid", bus.out_valid, 0);
    check_val("midrst_busy", busy, 0);
    check_val("midrst_swap_cnt", swap_cnt, 0);
    check_val("midrst_out_data", bus.out_data, 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    f = '{4'd2, 4'd2, 4'd2, 4'd2};
    run_frame(f, 0, 0, 1'b0);

    // Random frames with random idles, back-pressure and ignored-input noise.
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < DEPTH; i++) f[i] = 4'($urandom_range(0, 15));
      run_frame(f, 2, 2, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog: a stuck DUT cannot hang the run.
  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation timeout");
  end
endmodule
